// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the radix-2 butterfly blocks of the FFT/IFFT path.
//   PairStateType : two-state pair sequencer encoding (PAIR_0 = expecting the
//                   first sample of a pair, PAIR_1 = expecting the second).
//   FWD_GROWTH    : bits of word growth added by one forward radix-2 stage.
//   SEXT_MAX_W    : widest vector the sign_extend helper handles.
//   sign_extend() : replicates bit (width-1) of a value into all upper bits.
// -----------------------------------------------------------------------------
package fft_pkg;

   typedef enum logic {
      PAIR_0 = 1'b0,
      PAIR_1 = 1'b1
   } PairStateType;

   localparam int FWD_GROWTH = 1;
   localparam int SEXT_MAX_W = 64;

   // Sign-extend the low 'width' bits of val to SEXT_MAX_W bits; callers
   // narrow the result with a size cast. width must be at least 1.
   function automatic logic [SEXT_MAX_W-1:0] sign_extend(
      input logic [SEXT_MAX_W-1:0] val,
      input int                    width
   );
      logic [SEXT_MAX_W-1:0] res;
      res = {SEXT_MAX_W{1'b0}};
      for (int i = 0; i < SEXT_MAX_W; i++) begin
         if (i >= width) begin
            res[i] = val[width-1];
         end else begin
            res[i] = val[i];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/radix_2_inv_butterfly.sv
// -----------------------------------------------------------------------------
// radix_2_inv_butterfly
// Inverse radix-2 butterfly. Takes the serial pair X0, X1 produced by a forward
// butterfly (DATA_WIDTH+1 bits) and emits x0 = (X0+X1)/2 then x1 = (X0-X1)/2
// (DATA_WIDTH bits). Halving uses an arithmetic shift (floor), and the result
// wraps on overflow.
//
// Latency, counted in enabled cycles from the edge that accepts X1 (edge 0):
// x0 is presented after edge 2 and x1 after edge 3, each with a one-cycle
// validOut strobe. Back-to-back pairs give a continuous validOut.
//
// Ports:
//   clkIn    in   clock
//   rstIn    in   synchronous active-high reset
//   enIn     in   clock enable; when low every register holds
//   validIn  in   dataIn carries a sample (order X0, X1)
//   dataIn   in   signed sample, DATA_WIDTH+1 bits
//   validOut out  dataOut carries a reconstructed sample
//   dataOut  out  signed sample, DATA_WIDTH bits (order x0, x1)
//   errOut   out  only with IBFLY_PAIR_CHECK_EN: pair is not a legal forward
//                 butterfly output (odd sum) or a result does not fit
//
// Build option: `define IBFLY_PAIR_CHECK_EN to add errOut and its check logic.
// -----------------------------------------------------------------------------
module radix_2_inv_butterfly
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                             clkIn,
   input  logic                             rstIn,
   input  logic                             enIn,
   input  logic                             validIn,
   input  logic [DATA_WIDTH+FWD_GROWTH-1:0] dataIn,
   output logic                             validOut,
   output logic [DATA_WIDTH-1:0]            dataOut
`ifdef IBFLY_PAIR_CHECK_EN
   ,
   output logic                             errOut
`endif
);

   localparam int IN_W  = DATA_WIDTH + FWD_GROWTH;
   localparam int ACC_W = IN_W + 1;

   PairStateType            r_state;
   logic [IN_W-1:0]         r_hold;
   logic signed [ACC_W-1:0] r_sum;
   logic signed [ACC_W-1:0] r_diff;
   logic                    r_v0;     // sum/diff registers hold a fresh pair
   logic                    r_v1;     // scaled results r_o0/r_o1 are fresh
   logic                    r_v2;     // x1 waiting in r_x1 for its slot
   logic [DATA_WIDTH-1:0]   r_o0;
   logic [DATA_WIDTH-1:0]   r_o1;
   logic [DATA_WIDTH-1:0]   r_x1;

   logic signed [ACC_W-1:0] w_hold_ext;
   logic signed [ACC_W-1:0] w_data_ext;

   assign w_hold_ext = ACC_W'(sign_extend(SEXT_MAX_W'(r_hold), IN_W));
   assign w_data_ext = ACC_W'(sign_extend(SEXT_MAX_W'(dataIn), IN_W));

   // Pair capture FSM: hold X0, form full-precision sum and difference on X1.
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         r_state <= PAIR_0;
         r_hold  <= {IN_W{1'b0}};
         r_sum   <= {ACC_W{1'b0}};
         r_diff  <= {ACC_W{1'b0}};
         r_v0    <= 1'b0;
      end else if (enIn) begin
         r_v0 <= 1'b0;
         case (r_state)
            PAIR_0: begin
               if (validIn) begin
                  r_hold  <= dataIn;
                  r_state <= PAIR_1;
               end
            end
            PAIR_1: begin
               if (validIn) begin
                  r_sum   <= w_hold_ext + w_data_ext;
                  r_diff  <= w_hold_ext - w_data_ext;
                  r_v0    <= 1'b1;
                  r_state <= PAIR_0;
               end
            end
            default: begin
               r_state <= PAIR_0;
            end
         endcase
      end
   end

`ifdef IBFLY_PAIR_CHECK_EN
   logic r_err1;    // error flag travelling with r_o0/r_o1
   logic r_xerr;    // error flag travelling with r_x1
`endif

   // Output sequencer: scale the pair, then emit x0 and x1 in successive slots.
   // r_o0/r_o1 and r_x1 form a two-deep holding stage so a pending x1 survives
   // while the next pair's results are being scaled.
   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         r_v1     <= 1'b0;
         r_v2     <= 1'b0;
         r_o0     <= {DATA_WIDTH{1'b0}};
         r_o1     <= {DATA_WIDTH{1'b0}};
         r_x1     <= {DATA_WIDTH{1'b0}};
         validOut <= 1'b0;
         dataOut  <= {DATA_WIDTH{1'b0}};
`ifdef IBFLY_PAIR_CHECK_EN
         r_err1   <= 1'b0;
         r_xerr   <= 1'b0;
         errOut   <= 1'b0;
`endif
      end else if (enIn) begin
         r_v1 <= r_v0;
         if (r_v0) begin
            // Halve by arithmetic shift (floor), keep the low bits (wrap).
            r_o0 <= DATA_WIDTH'(r_sum >>> 1);
            r_o1 <= DATA_WIDTH'(r_diff >>> 1);
`ifdef IBFLY_PAIR_CHECK_EN
            // Odd sum, or a halved result whose top two sum/diff bits differ
            // (does not fit DATA_WIDTH signed).
            r_err1 <= r_sum[0]
                    | (r_sum[ACC_W-1]  ^ r_sum[ACC_W-2])
                    | (r_diff[ACC_W-1] ^ r_diff[ACC_W-2]);
`endif
         end
         if (r_v1) begin
            validOut <= 1'b1;
            dataOut  <= r_o0;
            r_x1     <= r_o1;
            r_v2     <= 1'b1;
`ifdef IBFLY_PAIR_CHECK_EN
            errOut   <= r_err1;
            r_xerr   <= r_err1;
`endif
         end else if (r_v2) begin
            validOut <= 1'b1;
            dataOut  <= r_x1;
            r_v2     <= 1'b0;
`ifdef IBFLY_PAIR_CHECK_EN
            errOut   <= r_xerr;
`endif
         end else begin
            validOut <= 1'b0;
`ifdef IBFLY_PAIR_CHECK_EN
            errOut   <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_radix_2_inv_butterfly.sv
// -----------------------------------------------------------------------------
// tb_radix_2_inv_butterfly
// Directed self-checking bench for radix_2_inv_butterfly (DATA_WIDTH = 16).
// Each task drives a short cycle table and compares validOut/dataOut after
// every driven edge against hand-computed values. The loopback task builds
// forward-butterfly pairs (a+b, a-b) in the bench and expects a, b back.
// Build with IBFLY_PAIR_CHECK_EN defined to also exercise errOut.
// -----------------------------------------------------------------------------
module tb_radix_2_inv_butterfly;

   localparam int DW = 16;

   logic          clkIn;
   logic          rstIn;
   logic          enIn;
   logic          validIn;
   logic [DW:0]   dataIn;
   logic          validOut;
   logic [DW-1:0] dataOut;
`ifdef IBFLY_PAIR_CHECK_EN
   logic          errOut;
`endif

   int checks;
   int errors;

   radix_2_inv_butterfly #(.DATA_WIDTH(DW)) dut (
      .clkIn    (clkIn),
      .rstIn    (rstIn),
      .enIn     (enIn),
      .validIn  (validIn),
      .dataIn   (dataIn),
      .validOut (validOut),
      .dataOut  (dataOut)
`ifdef IBFLY_PAIR_CHECK_EN
      ,
      .errOut   (errOut)
`endif
   );

   initial clkIn = 1'b0;
   always #5 clkIn = ~clkIn;

   // Apply inputs at the falling edge, then return 1ns after the rising edge.
   task automatic drive(input logic r, input logic e, input logic v, input logic [DW:0] d);
      @(negedge clkIn);
      rstIn   = r;
      enIn    = e;
      validIn = v;
      dataIn  = d;
      @(posedge clkIn);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b1, 1'b0, 17'd0);
      drive(1'b1, 1'b1, 1'b0, 17'd0);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (validOut !== 1'b0 || dataOut !== 16'd0) begin
         errors++;
         $display("FAIL reset_values: validOut=%0b dataOut=%0d, want 0/0", validOut, dataOut);
      end
`ifdef IBFLY_PAIR_CHECK_EN
      checks++;
      if (errOut !== 1'b0) begin
         errors++;
         $display("FAIL reset_err: errOut=%0b, want 0", errOut);
      end
`endif
      // Pair 7,1 -> x0=4, x1=3; reset lands in x0's slot and must kill x1.
      drive(1'b0, 1'b1, 1'b1, 17'sd7);
      drive(1'b0, 1'b1, 1'b1, 17'sd1);
      drive(1'b0, 1'b1, 1'b0, 17'd0);
      drive(1'b0, 1'b1, 1'b0, 17'd0);
      checks++;
      if (validOut !== 1'b1 || dataOut !== 16'd4) begin
         errors++;
         $display("FAIL reset_pre_x0: validOut=%0b dataOut=%0d, want 1/4", validOut, dataOut);
      end
      for (int i = 0; i < 3; i++) begin
         drive((i == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0, 17'd0);
         checks++;
         if (validOut !== 1'b0 || dataOut !== 16'd0) begin
            errors++;
            $display("FAIL reset_flush[%0d]: validOut=%0b dataOut=%0d, want 0/0", i, validOut, dataOut);
         end
      end
   endtask

   task automatic test_basic();
      logic              v_a [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic signed [DW:0] d_a [6] = '{17'sd5, -17'sd3, 17'sd0, 17'sd0, 17'sd0, 17'sd0};
      logic              ev  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic signed [DW-1:0] ed [6] = '{16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd4, 16'sd4};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b1, v_a[i], d_a[i]);
         checks++;
         if (validOut !== ev[i] || dataOut !== ed[i]) begin
            errors++;
            $display("FAIL basic[%0d]: validOut=%0b dataOut=%0d, want %0b/%0d",
                     i, validOut, $signed(dataOut), ev[i], ed[i]);
         end
      end
   endtask

   task automatic test_enable();
      // enIn 1,0,1,0 during the pair; the en=0 validIn (123) must be ignored.
      logic              e_a [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic              v_a [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic signed [DW:0] d_a [10] = '{17'sd32767, 17'sd123, 17'sd32767, 17'sd0, 17'sd0,
                                       17'sd0, 17'sd0, 17'sd0, 17'sd0, 17'sd0};
      logic              ev  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic signed [DW-1:0] ed [10] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
                                        16'sd32767, 16'sd32767, 16'sd0, 16'sd0, 16'sd0};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, e_a[i], v_a[i], d_a[i]);
         checks++;
         if (validOut !== ev[i] || dataOut !== ed[i]) begin
            errors++;
            $display("FAIL enable[%0d]: validOut=%0b dataOut=%0d, want %0b/%0d",
                     i, validOut, $signed(dataOut), ev[i], ed[i]);
         end
      end
   endtask

   task automatic test_reset_mid_pair();
      logic              r_a [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic              v_a [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic signed [DW:0] d_a [8] = '{17'sd100, 17'sd0, 17'sd10, 17'sd6, 17'sd0, 17'sd0, 17'sd0, 17'sd0};
      logic              ev  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic signed [DW-1:0] ed [8] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd8, 16'sd2, 16'sd2};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(r_a[i], 1'b1, v_a[i], d_a[i]);
         checks++;
         if (validOut !== ev[i] || dataOut !== ed[i]) begin
            errors++;
            $display("FAIL reset_mid_pair[%0d]: validOut=%0b dataOut=%0d, want %0b/%0d",
                     i, validOut, $signed(dataOut), ev[i], ed[i]);
         end
      end
   endtask

   task automatic test_gapped();
      logic              v_a [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic signed [DW:0] d_a [9] = '{-17'sd8, 17'sd0, 17'sd0, 17'sd0, 17'sd2, 17'sd0, 17'sd0, 17'sd0, 17'sd0};
      logic              ev  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic signed [DW-1:0] ed [9] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
                                       -16'sd3, -16'sd5, -16'sd5};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(1'b0, 1'b1, v_a[i], d_a[i]);
         checks++;
         if (validOut !== ev[i] || dataOut !== ed[i]) begin
            errors++;
            $display("FAIL gapped[%0d]: validOut=%0b dataOut=%0d, want %0b/%0d",
                     i, validOut, $signed(dataOut), ev[i], ed[i]);
         end
      end
   endtask

   // Forward butterfly in the bench feeding the DUT with 1000 continuous samples.
   task automatic test_back_to_back();
      localparam int NP = 500;
      logic signed [DW-1:0] exp_q [$];
      logic signed [DW:0]   in_q  [$];
      int a;
      int b;
      int total;
      logic exp_v;
      logic signed [DW-1:0] exp_d;
      for (int p = 0; p < NP; p++) begin
         a = int'($urandom_range(32'd65535, 32'd0)) - 32768;
         b = int'($urandom_range(32'd65535, 32'd0)) - 32768;
         in_q.push_back(17'(a + b));
         in_q.push_back(17'(a - b));
         exp_q.push_back(16'(a));
         exp_q.push_back(16'(b));
      end
      do_reset();
      total = 2 * NP + 4;
      for (int i = 0; i < total; i++) begin
         if (i < 2 * NP) begin
            drive(1'b0, 1'b1, 1'b1, in_q[i]);
         end else begin
            drive(1'b0, 1'b1, 1'b0, 17'd0);
         end
         exp_v = (i >= 3) && (i < 2 * NP + 3);
         checks++;
         if (validOut !== exp_v) begin
            errors++;
            $display("FAIL b2b_valid[%0d]: validOut=%0b, want %0b", i, validOut, exp_v);
         end
         if (exp_v) begin
            exp_d = exp_q.pop_front();
            checks++;
            if (dataOut !== exp_d) begin
               errors++;
               $display("FAIL b2b_data[%0d]: dataOut=%0d, want %0d", i, $signed(dataOut), exp_d);
            end
         end
`ifdef IBFLY_PAIR_CHECK_EN
         checks++;
         if (errOut !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err[%0d]: errOut=%0b, want 0", i, errOut);
         end
`endif
      end
   endtask

`ifdef IBFLY_PAIR_CHECK_EN
   task automatic test_pair_check();
      // 3,2 -> 2,0 with errOut high in both slots; 4,2 -> 3,1 with errOut low.
      logic              v_a [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic signed [DW:0] d_a [11] = '{17'sd3, 17'sd2, 17'sd0, 17'sd0, 17'sd0, 17'sd4, 17'sd2,
                                       17'sd0, 17'sd0, 17'sd0, 17'sd0};
      logic              ev  [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic signed [DW-1:0] ed [11] = '{16'sd0, 16'sd0, 16'sd0, 16'sd2, 16'sd0, 16'sd0, 16'sd0,
                                        16'sd0, 16'sd3, 16'sd1, 16'sd1};
      logic              ee  [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      for (int i = 0; i < 11; i++) begin
         drive(1'b0, 1'b1, v_a[i], d_a[i]);
         checks++;
         if (validOut !== ev[i] || dataOut !== ed[i] || errOut !== ee[i]) begin
            errors++;
            $display("FAIL pair_check[%0d]: validOut=%0b dataOut=%0d errOut=%0b, want %0b/%0d/%0b",
                     i, validOut, $signed(dataOut), errOut, ev[i], ed[i], ee[i]);
         end
      end
   endtask
`endif

   initial begin
      checks  = 0;
      errors  = 0;
      rstIn   = 1'b1;
      enIn    = 1'b0;
      validIn = 1'b0;
      dataIn  = 17'd0;
      test_reset();
      test_basic();
      test_enable();
      test_reset_mid_pair();
      test_gapped();
      test_back_to_back();
`ifdef IBFLY_PAIR_CHECK_EN
      test_pair_check();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
